// File: rtl/vx_writeback_arb.sv
// Writeback stage: merges ALU/JAL results and queued memory responses into one registered GPR write port.
// Define VX_WB_RR_EN for round-robin arbitration; otherwise queued memory responses have fixed priority.
module vx_writeback_arb #(
  parameter int NT    = 4,
  parameter int NW    = 8,
  parameter int DEPTH = 4,
  localparam int WW   = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [NT*32-1:0]   alu_result,
  input  logic [31:0]        alu_pc_next,
  input  logic [4:0]         alu_rd,
  input  logic [1:0]         alu_wb,
  input  logic [NT-1:0]      alu_mask,
  input  logic [WW-1:0]      alu_warp,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  logic [NT*32-1:0]   mem_result,
  input  logic [4:0]         mem_rd,
  input  logic [NT-1:0]      mem_mask,
  input  logic [WW-1:0]      mem_warp,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [NT*32-1:0]   wb_data,
  output logic [4:0]         wb_rd,
  output logic [NT-1:0]      wb_mask,
  output logic [WW-1:0]      wb_warp
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {WB_NO, WB_ALU, WB_MEM, WB_JAL} wb_kind_e;

  logic [NT*32-1:0] q_data [DEPTH];
  logic [4:0]       q_rd   [DEPTH];
  logic [NT-1:0]    q_mask [DEPTH];
  logic [WW-1:0]    q_warp [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic             free, fifo_has, full, alu_is_write, alu_cand;
  logic             grant_alu, grant_mem, push, pop, load_alu;
  logic [NT*32-1:0] alu_data;

`ifdef VX_WB_RR_EN
  typedef enum logic {RR_ALU, RR_MEM} rr_e;
  rr_e rr_q, rr_d;

  always_ff @(posedge clk) begin
    if (!reset) rr_q <= RR_ALU;
    else        rr_q <= rr_d;
  end
`endif

  always_comb begin
    free         = !wb_valid || wb_ready;
    fifo_has     = (count != '0);
    full         = (count == FULL_CNT);
    alu_is_write = (alu_wb == WB_ALU) || (alu_wb == WB_JAL);
    alu_cand     = alu_valid && alu_is_write;
`ifdef VX_WB_RR_EN
    // Full queue overrides the pointer so the FIFO cannot be starved into overflow.
    grant_alu = alu_cand && (!fifo_has || (!full && (rr_q == RR_ALU)));
`else
    grant_alu = alu_cand && !fifo_has;
`endif
    grant_mem = fifo_has && !grant_alu;
    pop       = free && grant_mem;
    load_alu  = free && grant_alu;
    alu_ready = reset && free && (grant_alu || !alu_is_write || !fifo_has);
    mem_ready = reset && !full;
    push      = mem_valid && mem_ready;
    alu_data  = (alu_wb == WB_JAL) ? {NT{alu_pc_next}} : alu_result;
`ifdef VX_WB_RR_EN
    rr_d = rr_q;
    if (load_alu)  rr_d = RR_MEM;
    else if (pop)  rr_d = RR_ALU;
`endif
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= mem_result;
      q_rd[wr_ptr]   <= mem_rd;
      q_mask[wr_ptr] <= mem_mask;
      q_warp[wr_ptr] <= mem_warp;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
      wb_mask  <= '0;
      wb_warp  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
      if (free) begin
        wb_valid <= load_alu || pop;
        if (load_alu) begin
          wb_data <= alu_data;
          wb_rd   <= alu_rd;
          wb_mask <= alu_mask;
          wb_warp <= alu_warp;
        end else if (pop) begin
          wb_data <= q_data[rd_ptr];
          wb_rd   <= q_rd[rd_ptr];
          wb_mask <= q_mask[rd_ptr];
          wb_warp <= q_warp[rd_ptr];
        end
      end
    end
  end

endmodule

// File: tb/tb_vx_writeback_arb.sv
// Directed bench for vx_writeback_arb: ALU vector table plus multi-cycle queue/arbitration/reset sequences.
module tb_vx_writeback_arb;

  localparam int NT = 4;
  localparam int NW = 8;
  localparam int DEPTH = 4;
  localparam int WW = 3;

  logic clk = 1'b0;
  logic reset;
  logic alu_valid, alu_ready;
  logic [NT*32-1:0] alu_result;
  logic [31:0] alu_pc_next;
  logic [4:0] alu_rd;
  logic [1:0] alu_wb;
  logic [NT-1:0] alu_mask;
  logic [WW-1:0] alu_warp;
  logic mem_valid, mem_ready;
  logic [NT*32-1:0] mem_result;
  logic [4:0] mem_rd;
  logic [NT-1:0] mem_mask;
  logic [WW-1:0] mem_warp;
  logic wb_valid, wb_ready;
  logic [NT*32-1:0] wb_data;
  logic [4:0] wb_rd;
  logic [NT-1:0] wb_mask;
  logic [WW-1:0] wb_warp;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vx_writeback_arb #(.NT(NT), .NW(NW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_result(alu_result),
    .alu_pc_next(alu_pc_next), .alu_rd(alu_rd), .alu_wb(alu_wb),
    .alu_mask(alu_mask), .alu_warp(alu_warp),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_result(mem_result),
    .mem_rd(mem_rd), .mem_mask(mem_mask), .mem_warp(mem_warp),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_mask(wb_mask), .wb_warp(wb_warp)
  );

  typedef struct {
    logic [1:0]   wb;
    logic [127:0] res;
    logic [31:0]  pc;
    logic [4:0]   rd;
    logic [3:0]   mask;
    logic [2:0]   warp;
    logic         exp_valid;
    logic [127:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic drive_alu(input logic [1:0] k, input logic [127:0] r, input logic [31:0] pc,
                           input logic [4:0] rd, input logic [3:0] m, input logic [2:0] w);
    alu_valid = 1'b1; alu_wb = k; alu_result = r; alu_pc_next = pc;
    alu_rd = rd; alu_mask = m; alu_warp = w;
  endtask

  task automatic drive_mem(input logic [127:0] r, input logic [4:0] rd, input logic [3:0] m,
                           input logic [2:0] w);
    mem_valid = 1'b1; mem_result = r; mem_rd = rd; mem_mask = m; mem_warp = w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int ga, gm;
    logic exp_alu;
    logic [127:0] exp_d;

    vecs[0] = '{2'd3, {4{32'h1234_5678}}, 32'h0000_1004, 5'd5, 4'hF, 3'd2, 1'b1, {4{32'h0000_1004}}};
    vecs[1] = '{2'd1, 128'h0000_0004_0000_0003_0000_0002_0000_0001, 32'h2000, 5'd9, 4'h5, 3'd7,
                1'b1, 128'h0000_0004_0000_0003_0000_0002_0000_0001};
    vecs[2] = '{2'd0, {4{32'hAAAA_AAAA}}, 32'h3000, 5'd1, 4'hF, 3'd1, 1'b0, 128'h0};
    vecs[3] = '{2'd2, {4{32'hBBBB_BBBB}}, 32'h4000, 5'd2, 4'hF, 3'd1, 1'b0, 128'h0};
    vecs[4] = '{2'd3, {4{32'h5555_5555}}, 32'hFFFF_FFFC, 5'd31, 4'h0, 3'd0, 1'b1, {4{32'hFFFF_FFFC}}};
    vecs[5] = '{2'd1, {4{32'hFFFF_FFFF}}, 32'h0, 5'd0, 4'h9, 3'd3, 1'b1, {4{32'hFFFF_FFFF}}};

    reset = 1'b0; wb_ready = 1'b1;
    alu_valid = 1'b1; alu_wb = 2'd1; alu_result = '1; alu_pc_next = '0;
    alu_rd = '0; alu_mask = '0; alu_warp = '0;
    mem_valid = 1'b0; mem_result = '0; mem_rd = '0; mem_mask = '0; mem_warp = '0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_wb_valid", 128'(wb_valid), 128'(0));
    chk("rst_wb_data", wb_data, 128'h0);
    chk("rst_wb_rd", 128'(wb_rd), 128'(0));
    chk("rst_alu_ready", 128'(alu_ready), 128'(0));
    chk("rst_mem_ready", 128'(mem_ready), 128'(0));
    chk("rst_count", 128'(dut.count), 128'(0));
    @(negedge clk);
    reset = 1'b1; idle(); #1;
    chk("rel_mem_ready", 128'(mem_ready), 128'(1));
    chk("rel_alu_ready", 128'(alu_ready), 128'(1));
    chk("rel_wb_valid", 128'(wb_valid), 128'(0));

    // ALU vector table
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_alu(vecs[i].wb, vecs[i].res, vecs[i].pc, vecs[i].rd, vecs[i].mask, vecs[i].warp);
      #1 chk($sformatf("vec%0d_alu_ready", i), 128'(alu_ready), 128'(1));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), 128'(wb_valid), 128'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_data", i), wb_data, vecs[i].exp_data);
        chk($sformatf("vec%0d_rd", i), 128'(wb_rd), 128'(vecs[i].rd));
        chk($sformatf("vec%0d_mask", i), 128'(wb_mask), 128'(vecs[i].mask));
        chk($sformatf("vec%0d_warp", i), 128'(wb_warp), 128'(vecs[i].warp));
      end
    end
    @(negedge clk); idle();

    // Single memory response: two-cycle latency
    @(negedge clk);
    drive_mem({4{32'hDEAD_BEEF}}, 5'd7, 4'hF, 3'd1);
    #1 chk("mem1_ready", 128'(mem_ready), 128'(1));
    @(posedge clk); #1 chk("mem1_valid_early", 128'(wb_valid), 128'(0));
    @(negedge clk); idle();
    @(posedge clk); #1;
    chk("mem1_valid", 128'(wb_valid), 128'(1));
    chk("mem1_data", wb_data, {4{32'hDEAD_BEEF}});
    chk("mem1_rd", 128'(wb_rd), 128'(7));
    chk("mem1_warp", 128'(wb_warp), 128'(1));
    chk("mem1_count", 128'(dut.count), 128'(0));
    @(posedge clk); #1 chk("mem1_done", 128'(wb_valid), 128'(0));

    // Backpressure: fill queue behind a stalled output
    @(negedge clk);
    wb_ready = 1'b0;
    drive_alu(2'd3, '0, 32'h11, 5'd1, 4'hF, 3'd4);
    @(posedge clk); #1 chk("stall_valid", 128'(wb_valid), 128'(1));
    @(negedge clk); idle();
    for (int k = 0; k <= DEPTH; k++) begin
      @(negedge clk);
      drive_mem({4{32'hC0 + 32'(k)}}, 5'(k + 10), 4'hF, 3'(k));
      #1 chk($sformatf("fill%0d_mem_ready", k), 128'(mem_ready), 128'(k < DEPTH));
      @(posedge clk); #1;
      chk($sformatf("fill%0d_hold_data", k), wb_data, {4{32'h11}});
      chk($sformatf("fill%0d_hold_rd", k), 128'(wb_rd), 128'(1));
      chk($sformatf("fill%0d_hold_valid", k), 128'(wb_valid), 128'(1));
    end
    @(negedge clk); idle();
    chk("full_count", 128'(dut.count), 128'(DEPTH));
    chk("full_mem_ready", 128'(mem_ready), 128'(0));
    wb_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      @(posedge clk); #1;
      chk($sformatf("drain%0d_data", k), wb_data, {4{32'hC0 + 32'(k)}});
      chk($sformatf("drain%0d_rd", k), 128'(wb_rd), 128'(k + 10));
    end
    @(posedge clk); #1;
    chk("drain_end_valid", 128'(wb_valid), 128'(0));
    chk("drain_end_count", 128'(dut.count), 128'(0));

    // Both sources continuously valid
    ga = 0; gm = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (!alu_valid || alu_ready) ;
      drive_alu(2'd1, {4{32'hA000_0000 + 32'(ga)}}, '0, 5'd2, 4'hF, 3'd5);
      drive_mem({4{32'hB000_0000 + 32'(gm + (c > 0 ? 1 : 0))}}, 5'd3, 4'hF, 3'd6);
`ifdef VX_WB_RR_EN
      exp_alu = (c % 2 == 0);
`else
      exp_alu = (c == 0);
`endif
      @(posedge clk); #1;
      exp_d = exp_alu ? {4{32'hA000_0000 + 32'(ga)}} : {4{32'hB000_0000 + 32'(gm)}};
      chk($sformatf("arb%0d_valid", c), 128'(wb_valid), 128'(1));
      chk($sformatf("arb%0d_data", c), wb_data, exp_d);
      if (exp_alu) ga++; else gm++;
    end
    @(negedge clk); idle();
    repeat (6) @(posedge clk);
    #1 chk("arb_drain_count", 128'(dut.count), 128'(0));

    // No-write ALU beat drains while FIFO head is granted
    @(negedge clk);
    drive_mem({4{32'h5555_0000}}, 5'd4, 4'hF, 3'd2);
    @(posedge clk);
    @(negedge clk);
    idle();
    drive_alu(2'd0, {4{32'h9999_9999}}, 32'h9, 5'd9, 4'hF, 3'd0);
    #1 chk("nowr_alu_ready", 128'(alu_ready), 128'(1));
    @(posedge clk); #1;
    chk("nowr_valid", 128'(wb_valid), 128'(1));
    chk("nowr_rd", 128'(wb_rd), 128'(4));
    chk("nowr_data", wb_data, {4{32'h5555_0000}});
    @(negedge clk); idle();
    @(posedge clk); #1 chk("nowr_no_write", 128'(wb_valid), 128'(0));

    // Reset with queued entries and a held output
    @(negedge clk);
    wb_ready = 1'b0;
    drive_alu(2'd3, '0, 32'h77, 5'd6, 4'hF, 3'd1);
    @(posedge clk);
    @(negedge clk); idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_mem({4{32'hE0 + 32'(k)}}, 5'd8, 4'hF, 3'd0);
      @(posedge clk);
    end
    @(negedge clk); idle();
    chk("prerst_count", 128'(dut.count), 128'(3));
    chk("prerst_valid", 128'(wb_valid), 128'(1));
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", 128'(wb_valid), 128'(0));
    chk("midrst_count", 128'(dut.count), 128'(0));
    chk("midrst_data", wb_data, 128'h0);
    @(negedge clk);
    reset = 1'b1; wb_ready = 1'b1;
    #1 chk("postrst_mem_ready", 128'(mem_ready), 128'(1));
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1 chk($sformatf("postrst%0d_no_stale", k), 128'(wb_valid), 128'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vx_writeback_arb.md
# vx_writeback_arb

Parametrised writeback stage that merges the ALU/JAL result stream and the memory-response stream into one registered register-file write port. Sits between execute/memory and the GPR file. It selects JAL PC data vs ALU result and buffers memory responses in a DEPTH-entry queue. It arbitrates both sources with valid/ready handshakes and holds output under register-file backpressure.

## Interface
- NT, 4: threads per warp; data buses are NT*32 bits, masks NT bits
- NW, 8: warps; warp id width WW = max(1, clog2(NW))
- DEPTH, 4: memory-response queue entries, power of two, >= 2
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- alu_valid / alu_ready  in / out  1 / 1  ALU channel handshake
- alu_result  in  NT*32  per-thread ALU result
- alu_pc_next  in  32  PC+4 for JAL link
- alu_rd, alu_wb, alu_mask, alu_warp  in  5, 2, NT, WW  destination, writeback kind, thread mask, warp
- mem_valid / mem_ready  in / out  1 / 1  memory-response handshake
- mem_result, mem_rd, mem_mask, mem_warp  in  NT*32, 5, NT, WW  load data and tags
- wb_valid / wb_ready  out / in  1 / 1  register-file write handshake
- wb_data, wb_rd, wb_mask, wb_warp  out  NT*32, 5, NT, WW  write payload

## Operation
- wb encoding: 0 WB_NO, 1 WB_ALU, 2 WB_MEM, 3 WB_JAL.
- ALU beat accepted when alu_valid && alu_ready.
  - WB_JAL: data = alu_pc_next replicated in all NT lanes.
  - WB_ALU: data = alu_result.
  - WB_NO or WB_MEM: beat consumed, no write produced.
- MEM beat accepted when mem_valid && mem_ready; pushed into FIFO (data, rd, mask, warp).
- mem_ready = (count < DEPTH), from registered count; a full queue never accepts, even with a same-cycle pop.
- Output register loads when slot free: free = !wb_valid || wb_ready.
- Candidates: ALU beat (valid, producing write) and FIFO head (count != 0).
- Arbitration when both present:
  - count == DEPTH: FIFO wins (anti-overflow).
  - Otherwise round-robin pointer picks; pointer flips to the other source after each grant.
- alu_ready = free && (ALU wins, or ALU beat is no-write, or FIFO empty); no-write ALU beats drain even when FIFO wins.
- Lanes with mask bit 0 pass data unchanged; masking is applied by the register file.
- Reset (reset == 0):
  - wb_valid=0, wb_data/rd/mask/warp=0, count=0, FIFO pointers=0, RR pointer=ALU.
  - alu_ready=0, mem_ready=0.
  - Any in-flight output or queued entries are discarded.

## Timing
- ALU accept to wb_valid: 1 cycle.
- MEM accept to earliest wb_valid: 2 cycles (enqueue, then select).
- Payload stable while wb_valid && !wb_ready.
- Full throughput: one write per cycle when wb_ready held high.
- Count update per cycle: +1 push, -1 pop, unchanged for both or neither.
- FIFO pointers wrap modulo DEPTH.
- First cycle after reset release: mem_ready=1, alu_ready=1, wb_valid=0.

## Configuration
- VX_WB_RR_EN defined: round-robin arbitration as above.
- VX_WB_RR_EN undefined:
  - Fixed priority: FIFO head wins whenever count != 0; ALU only when FIFO empty.
  - RR pointer removed; full-queue rule unchanged.

## Test plan
- ALU WB_JAL, pc_next=0x0000_1004, rd=5, warp=2, wb_ready=1 -> next cycle wb_valid=1, all NT lanes 0x0000_1004, wb_rd=5, wb_warp=2.
- Mem response 0xDEAD_BEEF all lanes, rd=7, no ALU traffic -> wb_valid two cycles after accept with that data, rd=7; count returns to 0.
- wb_ready=0, DEPTH+1 mem beats -> DEPTH accepted, mem_ready=0 on beat DEPTH+1, count=DEPTH; wb_valid payload unchanged for the entire stall.
- Both sources continuously valid, wb_ready=1, RR enabled -> grants alternate ALU, MEM, ALU, MEM; without VX_WB_RR_EN, MEM always wins until the queue empties.
- ALU WB_NO beat while FIFO head is granted -> alu_ready=1 that cycle; no write generated for the ALU beat.
- Reset asserted with count=3 and wb_valid=1 -> next edge: wb_valid=0, count=0; after release, no stale entries are emitted.
